// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and sizing helpers for the sequential square root
package sqrt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Step counter width; a single-step root still gets a 1-bit counter.
  function automatic int sqrt_cnt_w(input int w);
    return (w / 2 > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// rtl/sqrt_seq_if.sv - operand/result handshake bundle between the squares adder and sqrt_seq
interface sqrt_seq_if #(
  parameter int W = 8
);

  logic             data_rdy;
  logic [W-1:0]     radicand;
  logic             busy;
  logic             res_rdy;
  logic [W/2-1:0]   root;
  logic [W/2:0]     rem;
  logic             ovf;

  modport master (
    output data_rdy, radicand,
    input  busy, res_rdy, root, rem, ovf
  );

  modport slave (
    input  data_rdy, radicand,
    output busy, res_rdy, root, rem, ovf
  );

endinterface

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring root digit: try subtracting {root,01} from {rem,d}
module sqrt_step #(
  parameter int W = 8
) (
  input  logic [W/2:0]   rem_p,
  input  logic [W/2-1:0] root_p,
  input  logic [1:0]     d,
  output logic [W/2:0]   rem_p_n,
  output logic [W/2-1:0] root_p_n
);

  localparam int TW = W / 2 + 3;

  logic [TW-1:0] dividend;
  logic [TW-1:0] trial_sub;
  logic          fits;

  assign dividend  = {rem_p, d};
  assign trial_sub = {1'b0, root_p, 2'b01};

  // Full-width compare is the sign of the trial; the low bits of the
  // difference are exact because the kept remainder never exceeds 2*root.
  assign fits     = (dividend >= trial_sub);
  assign rem_p_n  = fits ? (dividend[W/2:0] - trial_sub[W/2:0]) : dividend[W/2:0];
  assign root_p_n = {root_p[W/2-2:0], fits};

endmodule

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - multi-cycle integer square root, one root bit resolved per clock
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rstn,
  sqrt_seq_if.slave bus
);

  localparam int HW = W / 2;
  localparam int CW = sqrt_cnt_w(W);

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shreg;
  logic [HW:0]    rem_p;
  logic [HW:0]    rem_p_n;
  logic [HW-1:0]  root_p;
  logic [HW-1:0]  root_p_n;
  logic [HW-1:0]  root_q;
  logic [HW:0]    rem_q;
  logic           ovf_q;
  logic           accept;
  logic           calc;
  logic           res_rdy;
  logic           last_step;

  assign last_step = (cnt == CW'(HW - 1));

  sqrt_step #(.W(W)) u_step (
    .rem_p    (rem_p),
    .root_p   (root_p),
    .d        (shreg[W-1:W-2]),
    .rem_p_n  (rem_p_n),
    .root_p_n (root_p_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.data_rdy) state_n = ST_CALC;
      ST_CALC: if (last_step) state_n = ST_DONE;
      ST_DONE: state_n = bus.data_rdy ? ST_CALC : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    calc    = 1'b0;
    res_rdy = 1'b0;
    case (state)
      ST_IDLE: accept = bus.data_rdy;
      ST_CALC: calc = 1'b1;
      ST_DONE: begin
        res_rdy = 1'b1;
        accept  = bus.data_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      shreg  <= '0;
      rem_p  <= '0;
      root_p <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      shreg  <= bus.radicand;
      rem_p  <= '0;
      root_p <= '0;
    end else if (calc) begin
      cnt    <= cnt + 1'b1;
      shreg  <= {shreg[W-3:0], 2'b00};
      rem_p  <= rem_p_n;
      root_p <= root_p_n;
      // Results publish on the same edge that moves into DONE.
      if (last_step) begin
        root_q <= root_p_n;
        rem_q  <= rem_p_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (calc && bus.data_rdy) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.busy    = calc;
  assign bus.res_rdy = res_rdy;
  assign bus.root    = root_q;
  assign bus.rem     = rem_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - self-checking bench for sqrt_seq with a timeline reference model
module tb_sqrt_seq;

  localparam int W  = 8;
  localparam int HW = W / 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  sqrt_seq_if #(.W(W)) sif ();

  sqrt_seq #(.W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc++;

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: an accepted operand finishes HW edges later; anything
  // arriving while a result is still outstanding only sets the overrun flag.
  int left = 0;
  int q_root = 0, q_rem = 0, q_rad = 0;
  int root_m = 0, rem_m = 0, done_rad = 0;
  bit res_m = 1'b0, ovf_m = 1'b0, was_busy;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      left = 0; res_m = 0; ovf_m = 0; root_m = 0; rem_m = 0;
    end else begin
      was_busy = (left > 0);
      res_m = 0;
      if (sif.data_rdy && was_busy) ovf_m = 1;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          res_m = 1; root_m = q_root; rem_m = q_rem; done_rad = q_rad;
        end
      end
      if (sif.data_rdy && !was_busy) begin
        q_rad  = int'(sif.radicand);
        q_root = isqrt(q_rad);
        q_rem  = q_rad - q_root * q_root;
        left   = HW;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(sif.busy), 32'(left > 0));
      check("res_rdy", 32'(sif.res_rdy), 32'(res_m));
      check("ovf", 32'(sif.ovf), 32'(ovf_m));
      check("root", 32'(sif.root), root_m);
      check("rem", 32'(sif.rem), rem_m);
      if (sif.res_rdy) begin
        check("identity", 32'(sif.root) * 32'(sif.root) + 32'(sif.rem), done_rad);
        check("rem_bound", 32'(32'(sif.rem) <= 2 * 32'(sif.root)), 32'd1);
      end
    end
  end

  task automatic pulse(input int v);
    @(negedge clk);
    sif.data_rdy = 1'b1;
    sif.radicand = W'(v);
    @(posedge clk);
    #1;
    sif.data_rdy = 1'b0;
    sif.radicand = W'($urandom_range(0, 255));
  endtask

  task automatic expect_result(input string name, input int r, input int m, output int busy_cycles);
    bit found;
    found = 0;
    busy_cycles = 0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (sif.res_rdy) begin
        found = 1;
        break;
      end
      if (sif.busy) busy_cycles++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: res_rdy got 0 expected 1 within %0d cycles", name, 4 * W);
    end else begin
      check({name, "_root"}, 32'(sif.root), r);
      check({name, "_rem"}, 32'(sif.rem), m);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int bc, t1, seen;
  int dir_v[4] = '{0, 2, 200, 255};
  int dir_r[4] = '{0, 1, 14, 15};
  int dir_m[4] = '{0, 1, 4, 30};

  initial begin
    sif.data_rdy = 1'b0;
    sif.radicand = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(sif.busy), 0);
    check("rst_res_rdy", 32'(sif.res_rdy), 0);
    check("rst_ovf", 32'(sif.ovf), 0);
    check("rst_root", 32'(sif.root), 0);
    check("rst_rem", 32'(sif.rem), 0);
    cmp_en = 1'b1;
    rstn = 1'b1;

    pulse(144);
    expect_result("r144", 12, 0, bc);
    check("r144_busy_cycles", bc, HW);

    for (int i = 0; i < 4; i++) begin
      pulse(dir_v[i]);
      expect_result($sformatf("dir%0d", dir_v[i]), dir_r[i], dir_m[i], bc);
      repeat (3) @(negedge clk);
      check($sformatf("hold%0d_root", dir_v[i]), 32'(sif.root), dir_r[i]);
      check($sformatf("hold%0d_rem", dir_v[i]), 32'(sif.rem), dir_m[i]);
    end

    pulse(255);
    expect_result("b2b_first", 15, 30, bc);
    t1 = cyc;
    sif.data_rdy = 1'b1;
    sif.radicand = W'(100);
    @(posedge clk);
    #1;
    sif.data_rdy = 1'b0;
    expect_result("b2b_second", 10, 0, bc);
    check("b2b_gap", cyc - t1, HW + 1);
    check("b2b_ovf", 32'(sif.ovf), 0);

    pulse(81);
    @(posedge clk);
    pulse(50);
    expect_result("ovr", 9, 0, bc);
    check("ovr_flag", 32'(sif.ovf), 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sif.res_rdy) seen++;
    end
    check("ovr_no_second", seen, 0);
    check("ovr_sticky", 32'(sif.ovf), 1);

    pulse(200);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_busy", 32'(sif.busy), 0);
    check("midrst_res_rdy", 32'(sif.res_rdy), 0);
    check("midrst_root", 32'(sif.root), 0);
    check("midrst_rem", 32'(sif.rem), 0);
    check("midrst_ovf", 32'(sif.ovf), 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (sif.res_rdy) seen++;
    end
    check("midrst_no_res", seen, 0);
    rstn = 1'b1;
    sif.data_rdy = 1'b1;
    sif.radicand = W'(49);
    @(posedge clk);
    #1;
    sif.data_rdy = 1'b0;
    expect_result("after_rst", 7, 0, bc);

    for (int v = 0; v < (1 << W); v++) begin
      pulse(v);
      expect_result($sformatf("sweep%0d", v), isqrt(v), v - isqrt(v) * isqrt(v), bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (400) begin
      @(negedge clk);
      sif.data_rdy = ($urandom_range(0, 3) == 0);
      sif.radicand = W'($urandom_range(0, 255));
    end
    @(negedge clk);
    sif.data_rdy = 1'b0;
    repeat (2 * W) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
